// File: rtl/b_another_frame_tx_pkg.sv
// Shared b-hierarchy constants for the frame link: frame size, beat index width, TX FSM states.
package hierIncludeBInclude_package;
  localparam int B_ANOTHER_SIZE = 9;
  localparam int B_IDX_W        = 4;

  typedef enum logic {B_TX_IDLE, B_TX_SEND} b_frame_tx_state_t;
endpackage

// File: rtl/b_another_frame_tx_hold.sv
// Frame hold register and word select for b_another_frame_tx.
// HIERINCLUDE_B_FRAME_PARITY_EN adds a registered parity path with word-0 error injection.
module b_another_frame_hold
  import hierIncludeBInclude_package::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic [B_ANOTHER_SIZE*DATA_W-1:0]    frame_data,
  input  logic [B_IDX_W-1:0]                  idx,
`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
  input  logic                                parity_err_inj,
  output logic                                word_parity,
`endif
  output logic [DATA_W-1:0]                   word
);
  logic [B_ANOTHER_SIZE-1:0][DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (load) hold_d = frame_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign word = hold_q[idx];

`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
  logic inj_q, inj_d;

  always_comb begin
    inj_d = inj_q;
    if (load) inj_d = parity_err_inj;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inj_q <= 1'b0;
    else     inj_q <= inj_d;
  end

  // Injected error only corrupts word 0 so the receiver sees exactly one bad beat.
  assign word_parity = (^word) ^ (inj_q && (idx == '0));
`endif
endmodule

// File: rtl/b_another_frame_tx.sv
// Serialises one B_ANOTHER_SIZE-word frame into a valid/ready beat stream, zero-bubble between frames.
// Optional parity output/injection under HIERINCLUDE_B_FRAME_PARITY_EN.
module b_another_frame_tx
  import hierIncludeBInclude_package::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_valid,
  output logic                              frame_ready,
  input  logic [B_ANOTHER_SIZE*DATA_W-1:0]  frame_data,
  output logic                              beat_valid,
  input  logic                              beat_ready,
  output logic [DATA_W-1:0]                 beat_data,
  output logic [B_IDX_W-1:0]                beat_idx,
  output logic                              beat_last,
`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
  input  logic                              parity_err_inj,
  output logic                              beat_parity,
`endif
  output logic                              busy,
  output logic [CNT_W-1:0]                  frame_count
);
  localparam logic [B_IDX_W-1:0] LAST_IDX = B_IDX_W'(B_ANOTHER_SIZE - 1);

  b_frame_tx_state_t state_q, state_d;
  logic [B_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               beat_xfer, frame_xfer;

  assign beat_last  = (idx_q == LAST_IDX);
  assign beat_xfer  = valid_q && beat_ready;
  assign frame_xfer = frame_valid && frame_ready;

  // Handing over on the final beat's transfer is what removes the inter-frame bubble.
  always_comb begin
    frame_ready = 1'b0;
    if (!rst) begin
      if (state_q == B_TX_IDLE) frame_ready = 1'b1;
      else                      frame_ready = valid_q && beat_last && beat_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      B_TX_IDLE: begin
        if (frame_xfer) begin
          state_d = B_TX_SEND;
          idx_d   = '0;
          valid_d = 1'b1;
        end
      end
      B_TX_SEND: begin
        if (beat_xfer) begin
          if (beat_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            if (!frame_xfer) begin
              state_d = B_TX_IDLE;
              valid_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + B_IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = B_TX_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= B_TX_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  b_another_frame_hold #(.DATA_W(DATA_W)) u_hold (
    .clk            (clk),
    .rst            (rst),
    .load           (frame_xfer),
    .frame_data     (frame_data),
    .idx            (idx_q),
`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
    .parity_err_inj (parity_err_inj),
    .word_parity    (beat_parity),
`endif
    .word           (beat_data)
  );

  assign beat_valid  = valid_q;
  assign beat_idx    = idx_q;
  assign busy        = valid_q;
  assign frame_count = cnt_q;
endmodule

// File: tb/tb_b_another_frame_tx.sv
// Directed bench for b_another_frame_tx: single frame, backpressure, back-to-back, wrap, mid-frame reset, parity.
module tb_b_another_frame_tx;
  import hierIncludeBInclude_package::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             frame_valid;
  logic                             frame_ready;
  logic [B_ANOTHER_SIZE*DATA_W-1:0] frame_data;
  logic                             beat_valid;
  logic                             beat_ready;
  logic [DATA_W-1:0]                beat_data;
  logic [B_IDX_W-1:0]               beat_idx;
  logic                             beat_last;
  logic                             busy;
  logic [CNT_W-1:0]                 frame_count;
`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
  logic                             parity_err_inj;
  logic                             beat_parity;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  b_another_frame_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .beat_valid     (beat_valid),
    .beat_ready     (beat_ready),
    .beat_data      (beat_data),
    .beat_idx       (beat_idx),
    .beat_last      (beat_last),
`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
    .parity_err_inj (parity_err_inj),
    .beat_parity    (beat_parity),
`endif
    .busy           (busy),
    .frame_count    (frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_words(input logic [7:0] base);
    for (int i = 0; i < B_ANOTHER_SIZE; i++) frame_data[i*DATA_W +: DATA_W] = base + 8'(i);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where beat 0 is visible.
  task automatic offer_frame(input logic [7:0] base);
    load_words(base);
    frame_valid = 1'b1;
    chk("idle_frame_ready", {31'd0, frame_ready}, 32'd1);
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic chk_beat(input logic [7:0] base, input int i);
    logic [7:0] w;
    w = base + 8'(i);
    chk("beat_valid", {31'd0, beat_valid}, 32'd1);
    chk("beat_data",  {24'd0, beat_data}, {24'd0, w});
    chk("beat_idx",   {28'd0, beat_idx}, 32'(i));
    chk("beat_last",  {31'd0, beat_last}, (i == 8) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_idle_done();
    chk("end_valid", {31'd0, beat_valid}, 32'd0);
    chk("end_busy",  {31'd0, busy}, 32'd0);
    chk("end_count", {16'd0, frame_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    rst = 1'b1; frame_valid = 1'b0; beat_ready = 1'b1; frame_data = '0;
`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
    parity_err_inj = 1'b0;
`endif
    exp_cnt = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
    chk("rst_valid",       {31'd0, beat_valid}, 32'd0);
    chk("rst_busy",        {31'd0, busy}, 32'd0);
    chk("rst_data",        {24'd0, beat_data}, 32'd0);
    chk("rst_idx",         {28'd0, beat_idx}, 32'd0);
    chk("rst_count",       {16'd0, frame_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame with continuous ready
    offer_frame(8'h10);
    for (int i = 0; i < 9; i++) begin
      chk_beat(8'h10, i);
      chk("busy_in_send", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1'b1;
    chk_idle_done();

    // Backpressure at idx 4
    offer_frame(8'h10);
    for (int i = 0; i < 4; i++) @(negedge clk);
    beat_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_beat(8'h10, 4);
      chk("bp_frame_ready", {31'd0, frame_ready}, 32'd0);
      @(negedge clk);
    end
    beat_ready = 1'b1;
    chk_beat(8'h10, 4);
    @(negedge clk);
    for (int i = 5; i < 9; i++) begin
      chk_beat(8'h10, i);
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1'b1;
    chk_idle_done();

    // Back-to-back: second frame offered continuously during first
    offer_frame(8'h10);
    load_words(8'h20);
    frame_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk_beat(8'h10, i);
      chk("b2b_frame_ready", {31'd0, frame_ready}, (i == 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    frame_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk_beat(8'h20, i);
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 2'd2;
    chk_idle_done();

    // Counter wrap
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    @(negedge clk);
    chk("wrap_pre", {16'd0, frame_count}, 32'h0000_FFFF);
    offer_frame(8'h30);
    for (int i = 0; i < 9; i++) @(negedge clk);
    exp_cnt = 16'h0000;
    chk_idle_done();

    // Reset mid-frame at idx 5
    offer_frame(8'h40);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk_beat(8'h40, 5);
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, beat_valid}, 32'd0);
    chk("mrst_idx",   {28'd0, beat_idx}, 32'd0);
    chk("mrst_data",  {24'd0, beat_data}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, frame_ready}, 32'd0);
    chk("mrst_count", {16'd0, frame_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", {16'd0, frame_count}, {16'd0, exp_cnt});
    offer_frame(8'h50);
    chk_beat(8'h50, 0);
    for (int i = 0; i < 9; i++) @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    chk_idle_done();

`ifdef HIERINCLUDE_B_FRAME_PARITY_EN
    // word0 = 0x07 (odd ones), word1 = 0x08
    offer_frame(8'h07);
    chk("par_w0", {31'd0, beat_parity}, 32'd1);
    @(negedge clk);
    chk("par_w1", {31'd0, beat_parity}, 32'd1);
    for (int i = 1; i < 9; i++) @(negedge clk);
    parity_err_inj = 1'b1;
    offer_frame(8'h07);
    parity_err_inj = 1'b0;
    chk("par_inj_w0", {31'd0, beat_parity}, 32'd0);
    @(negedge clk);
    chk("par_inj_w1", {31'd0, beat_parity}, 32'd1);
    for (int i = 1; i < 9; i++) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/b_another_frame_tx.md
Name: b_another_frame_tx

Overview:
- Transmit end of the b-block frame link. Accepts one frame of B_ANOTHER_SIZE (9) words in parallel over a valid/ready handshake and serialises it as 9 beats on a downstream valid/ready beat stream, flagging the final beat.
- The existing b-side frame receiver reassembles these beats. Sits in hierarchy b and uses constants from hierIncludeBInclude_package.

Parameters:
- DATA_W, 8, width of one beat word in bits.
- CNT_W, 16, width of the sent-frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- frame_valid  in  1  upstream frame is offered.
- frame_ready  out  1  block takes the frame this cycle.
- frame_data  in  B_ANOTHER_SIZE*DATA_W  word i at bits [i*DATA_W +: DATA_W]; word 0 is sent first.
- beat_valid  out  1  beat_data is valid.
- beat_ready  in  1  downstream accepts the beat.
- beat_data  out  DATA_W  current word.
- beat_idx  out  B_IDX_W (4)  index of the current word, 0..8.
- beat_last  out  1  high when beat_idx == B_ANOTHER_SIZE-1.
- busy  out  1  a frame is held or in transmission.
- frame_count  out  CNT_W  number of frames fully sent; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert at the flop level): state IDLE. beat_valid, beat_data, beat_idx, beat_last, busy and frame_count are all 0. frame_ready is 0 while rst is high. Any held frame is discarded.
- Beat handshake: a beat transfers when beat_valid && beat_ready.
- Frame handshake: a frame transfers when frame_valid && frame_ready.
- State IDLE:
  - frame_ready = 1.
  - On frame transfer: latch frame_data into the hold register, go to SEND. The next cycle has beat_valid=1, beat_idx=0, beat_data=word0.
  - Latency from frame transfer to first beat valid is exactly 1 cycle.
- State SEND:
  - beat_valid = 1 and busy = 1.
  - While beat_valid && !beat_ready, beat_data, beat_idx and beat_last are held stable.
  - On a beat transfer with idx < 8: idx increments and beat_data = word[idx+1].
  - On a beat transfer with idx == 8:
    - frame_count increments, wrapping from 0xFFFF to 0.
    - If frame_valid is high in the same cycle, the next frame is taken: frame_ready = 1 combinationally (frame_ready = beat_last && beat_ready). Stay in SEND with idx=0 and the new word0 on the next cycle, so there is no bubble between frames.
    - Otherwise go to IDLE with beat_valid=0 on the next cycle.
- In SEND, frame_ready = beat_valid && beat_last && beat_ready. frame_ready never depends on frame_valid.
- beat_valid never deasserts without a transfer.
- beat_data is driven from registers only. frame_data is sampled only on the frame transfer cycle.
- Sustained throughput is 1 beat per cycle: 9 cycles per frame with back-to-back frames.
- Reset asserted mid-frame: the partial frame is lost, no count increment, and all outputs return to their reset values immediately.

Optional Feature:
- Macro: HIERINCLUDE_B_FRAME_PARITY_EN.
- When defined:
  - Adds output beat_parity (1 bit) = even parity (XOR reduction) of beat_data, registered alongside beat_data and held stable under backpressure.
  - Adds input parity_err_inj (1 bit). When it is high on the frame transfer cycle, the parity of word 0 of that frame is inverted, for receiver testing.
- When undefined: neither port exists and there is no parity logic.

Decomposition:
- Package hierIncludeBInclude_package (shared):
  - B_ANOTHER_SIZE already exists.
  - Add localparam B_IDX_W = 4.
  - Add enum b_frame_tx_state_t {B_TX_IDLE, B_TX_SEND}.
- Sub-module b_another_frame_hold: the hold register plus word mux. It takes a load strobe, frame_data and idx, and outputs the word. This keeps the top to the FSM, counters and handshake.

Test Plan:
- Single frame, frame_data words 0x10..0x18, beat_ready=1 → beats 0x10..0x18 with idx 0..8 on 9 consecutive cycles starting 1 cycle after acceptance; beat_last only on 0x18; frame_count=1; then IDLE with busy=0.
- Backpressure: beat_ready=0 for 3 cycles at idx=4 → beat_data=0x14 and idx=4 held stable; frame_ready=0 throughout; transmission resumes at 0x15.
- Back-to-back: second frame (0x20..0x28) presented continuously → frame_ready pulses on the 0x18 transfer cycle; 0x20 appears the next cycle with no gap; 18 beats in 18 cycles; frame_count=2.
- Wrap: force frame_count to 0xFFFF, send one frame → frame_count=0x0000.
- Reset at idx=5 → outputs go to 0 the same cycle; after release, IDLE with frame_ready=1; next frame starts at idx=0 and frame_count is unchanged at 0.
- Parity (HIERINCLUDE_B_FRAME_PARITY_EN defined): word 0x07 → beat_parity=1; same frame with parity_err_inj=1 → beat_parity=0 on beat 0 only.
